// File: rtl/data_mem_pkg.sv
// Shared types and the lane-merge helper for the data RAM.
// Used by the write path, the write-first bypass and the init sweep FSM.
package data_mem_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } dmem_state_e;

   localparam int DMEM_WORD_BYTES = 4;

   function automatic logic [31:0] byte_merge(
      input logic [31:0] old_word,
      input logic [31:0] new_word,
      input logic [3:0]  we
   );
      logic [31:0] merged;
      merged = old_word;
      for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
         if (we[b]) begin
            merged[8*b +: 8] = new_word[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/data_mem_init.sv
// Power-up zero-fill sequencer: walks every word once, then reports ready.
// Sweep takes DEPTH_WORDS cycles after reset; requests are refused until done.
module data_mem_init
   import data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ready,
   output logic             sweep_we,
   output logic [IDX_W-1:0] sweep_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

   dmem_state_e      state, state_nxt;
   logic [IDX_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sweep_we  = 1'b0;
      ready     = 1'b0;
      case (state)
         INIT: begin
            sweep_we = 1'b1;
            cnt_nxt  = cnt + IDX_W'(1);
            if (cnt == LAST_IDX) begin
               state_nxt = READY;
            end
         end
         READY: begin
            ready = 1'b1;
         end
         default: begin
            state_nxt = INIT;
         end
      endcase
   end

   assign sweep_idx = cnt;

endmodule

// File: rtl/data_mem.sv
// Byte-enabled synchronous data RAM with zero-fill on reset; DATA_MEM_BYPASS_EN selects write-first collisions.
// Read data/rvalid/err one cycle after request; one request per cycle once data_ready_o is high.
module data_mem
   import data_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   input  logic [3:0]  data_we_i,
   input  logic        data_re_i,
   output logic [31:0] data_rdata_o,
   output logic        data_rvalid_o,
   output logic        data_ready_o,
   output logic        data_err_o
);

   localparam int          IDX_W   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] ADDR_HI = ADDR_LO + 33'(DMEM_WORD_BYTES * DEPTH_WORDS);

   logic [31:0]      mem [DEPTH_WORDS];
   logic             ready;
   logic             sweep_we;
   logic [IDX_W-1:0] sweep_idx;

   logic [32:0]      addr_ext;
   logic [31:0]      offset;
   logic [IDX_W-1:0] idx;
   logic             in_range;
   logic             accept;
   logic             wr_req, rd_req;
   logic             wr_hit, rd_hit, rd_oor, any_oor;
   logic [31:0]      rd_word;
   logic             unused_addr_bits;

   data_mem_init #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_init (
      .clk       (clk),
      .rst       (rst),
      .ready     (ready),
      .sweep_we  (sweep_we),
      .sweep_idx (sweep_idx)
   );

   // 33-bit compare keeps the top of the window from wrapping past 32'hFFFF_FFFF.
   assign addr_ext = {1'b0, data_addr_i};
   assign in_range = (addr_ext >= ADDR_LO) && (addr_ext < ADDR_HI);
   assign offset   = data_addr_i - BASE_ADDR;
   assign idx      = offset[IDX_W+1:2];
   assign unused_addr_bits = ^{offset[31:IDX_W+2], offset[1:0]};

   assign accept  = ready & ~rst;
   assign wr_req  = |data_we_i;
   assign rd_req  = data_re_i;
   assign wr_hit  = accept & wr_req & in_range;
   assign rd_hit  = accept & rd_req & in_range;
   assign rd_oor  = accept & rd_req & ~in_range;
   assign any_oor = accept & (rd_req | wr_req) & ~in_range;

   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem[sweep_idx] <= '0;
      end else if (wr_hit) begin
         mem[idx] <= byte_merge(mem[idx], data_wdata_i, data_we_i);
      end
   end

   always_comb begin
`ifdef DATA_MEM_BYPASS_EN
      rd_word = wr_hit ? byte_merge(mem[idx], data_wdata_i, data_we_i) : mem[idx];
`else
      rd_word = mem[idx];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_rdata_o  <= '0;
         data_rvalid_o <= 1'b0;
         data_err_o    <= 1'b0;
      end else begin
         data_rvalid_o <= rd_hit | rd_oor;
         data_err_o    <= any_oor;
         if (rd_hit) begin
            data_rdata_o <= rd_word;
         end else if (rd_oor) begin
            data_rdata_o <= '0;
         end
      end
   end

   assign data_ready_o = ready;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: sweep timing, byte lanes, window checks, collisions, mid-sweep reset, streaming.
// One DUT with BASE_ADDR=0x1000 and 16 words; all in-window addresses are BASE-relative.
module tb_data_mem;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef DATA_MEM_BYPASS_EN
   localparam logic [31:0] COLL_EXP = 32'hDEAD_BEEF;
`else
   localparam logic [31:0] COLL_EXP = 32'h0000_0000;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_we;
   logic        data_re;
   logic [31:0] data_rdata;
   logic        data_rvalid;
   logic        data_ready;
   logic        data_err;

   int errors = 0;
   int checks = 0;

   data_mem #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .data_addr_i   (data_addr),
      .data_wdata_i  (data_wdata),
      .data_we_i     (data_we),
      .data_re_i     (data_re),
      .data_rdata_o  (data_rdata),
      .data_rvalid_o (data_rvalid),
      .data_ready_o  (data_ready),
      .data_err_o    (data_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      data_re    = 1'b0;
      data_we    = 4'h0;
      data_wdata = 32'h0;
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
      data_addr = addr;
      data_re   = 1'b1;
      data_we   = 4'h0;
      cyc();
      check({tag, "_rvalid"}, 32'(data_rvalid), 32'h1);
      check({tag, "_rdata"}, data_rdata, exp_data);
      check({tag, "_err"}, 32'(data_err), 32'(exp_err));
      idle();
   endtask

   task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] we, input logic exp_err);
      data_addr  = addr;
      data_wdata = wdata;
      data_we    = we;
      data_re    = 1'b0;
      cyc();
      check({tag, "_err"}, 32'(data_err), 32'(exp_err));
      check({tag, "_rvalid"}, 32'(data_rvalid), 32'h0);
      idle();
   endtask

   // Runs from the cycle rst drops; probes a read at cycle 5 and the ready edge at 15/16.
   task automatic run_sweep(input string tag);
      for (int i = 1; i <= DEPTH; i++) begin
         if (i == 5) begin
            data_addr = BASE + 32'h8;
            data_re   = 1'b1;
         end
         cyc();
         if (i == 5) begin
            check({tag, "_early_rvalid"}, 32'(data_rvalid), 32'h0);
            check({tag, "_early_err"}, 32'(data_err), 32'h0);
            idle();
         end
         if (i == DEPTH - 1) check({tag, "_ready_lo"}, 32'(data_ready), 32'h0);
         if (i == DEPTH)     check({tag, "_ready_hi"}, 32'(data_ready), 32'h1);
      end
   endtask

   initial begin
      rst       = 1'b1;
      data_addr = 32'h0;
      idle();
      repeat (3) cyc();
      check("rst_rdata", data_rdata, 32'h0);
      check("rst_rvalid", 32'(data_rvalid), 32'h0);
      check("rst_err", 32'(data_err), 32'h0);
      check("rst_ready", 32'(data_ready), 32'h0);

      rst = 1'b0;
      run_sweep("sweep");
      do_read("sweep_rd8", BASE + 32'h8, 32'h0, 1'b0);

      do_write("be_wr_full", BASE + 32'h4, 32'hAABB_CCDD, 4'hF, 1'b0);
      do_write("be_wr_part", BASE + 32'h4, 32'h1122_3344, 4'b0101, 1'b0);
      do_read("be_rd", BASE + 32'h4, 32'hAA22_CC44, 1'b0);
      cyc();
      check("be_rvalid_drop", 32'(data_rvalid), 32'h0);

      do_read("oor_hi", BASE + 32'h40, 32'h0, 1'b1);
      do_write("oor_wr_lo", 32'h0000_0FFC, 32'hDEAD_0001, 4'hF, 1'b1);
      do_read("last_word", BASE + 32'h3C, 32'h0, 1'b0);
      do_read("oor_top", 32'hFFFF_FFFC, 32'h0, 1'b1);

      data_addr  = BASE + 32'h10;
      data_wdata = 32'hDEAD_BEEF;
      data_we    = 4'hF;
      data_re    = 1'b1;
      cyc();
      check("coll_rvalid", 32'(data_rvalid), 32'h1);
      check("coll_rdata", data_rdata, COLL_EXP);
      idle();
      do_read("coll_after", BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);

      for (int i = 0; i < 8; i++) begin
         do_write("stream_wr", BASE + 32'(4 * i), 32'(i) * 32'h0101_0101, 4'hF, 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         data_addr = BASE + 32'(4 * i);
         data_re   = 1'b1;
         cyc();
         check($sformatf("stream_rvalid%0d", i), 32'(data_rvalid), 32'h1);
         check($sformatf("stream_rdata%0d", i), data_rdata, 32'(i) * 32'h0101_0101);
      end
      idle();
      cyc();
      check("stream_end_rvalid", 32'(data_rvalid), 32'h0);

      do_write("ms_pre_wr", BASE + 32'h8, 32'h1234_5678, 4'hF, 1'b0);
      do_read("ms_pre_rd", BASE + 32'h8, 32'h1234_5678, 1'b0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 1; i <= 7; i++) cyc();
      check("ms_ready_mid", 32'(data_ready), 32'h0);
      rst = 1'b1;
      cyc();
      check("ms_rst_ready", 32'(data_ready), 32'h0);
      check("ms_rst_rvalid", 32'(data_rvalid), 32'h0);
      rst = 1'b0;
      run_sweep("ms");
      do_read("ms_rd8", BASE + 32'h8, 32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-organised synchronous data RAM.
- Acts as the responder on the core's data-memory interface, which carries address, write data, 4-bit byte write enable and read data.
- On reset it runs a zero-fill sweep over every word, then serves byte-enabled writes and registered reads with a fixed 1-cycle read latency.
- Flags accesses outside its address window.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; 4*DEPTH_WORDS-aligned.
- IDX_W, $clog2(DEPTH_WORDS): word-index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- data_addr_i  in  32  byte address; bits [1:0] ignored, since lane selection is done by the requester.
- data_wdata_i  in  32  write data, lane-aligned.
- data_we_i  in  4  byte write enables; bit n writes data_wdata_i[8n+7:8n].
- data_re_i  in  1  read request.
- data_rdata_o  out  32  registered read data.
- data_rvalid_o  out  1  pulses high 1 cycle after an accepted read.
- data_ready_o  out  1  high when requests are accepted (sweep complete).
- data_err_o  out  1  pulses high 1 cycle after an out-of-range request.

Interface rule: one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset values: data_rdata_o=0, data_rvalid_o=0, data_err_o=0, data_ready_o=0; FSM=INIT; sweep counter=0.
- FSM states: INIT and READY.
- INIT:
  - Each cycle writes 32'h0 to mem[cnt], then increments cnt.
  - When cnt==DEPTH_WORDS-1 is written, the next state is READY.
  - The sweep takes exactly DEPTH_WORDS cycles after rst deasserts, so data_ready_o rises on cycle DEPTH_WORDS.
  - Requests during INIT are ignored: no write, no rvalid, no err.
- READY: remains in READY until rst.
- rst asserted at any time, including mid-sweep, returns to INIT with cnt=0 and the sweep restarts from word 0.
- In-range test: BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS, computed with 33-bit arithmetic so there is no wrap at 32'hFFFF_FFFC.
- Word index = (addr-BASE_ADDR)[IDX_W+1:2].
- Write (READY, data_we_i!=0, in range):
  - Each enabled lane updates at the clock edge.
  - Disabled lanes are unchanged.
  - data_we_i==0 is not a write.
- Read (READY, data_re_i, in range):
  - data_rdata_o = mem[idx] on the next cycle, with data_rvalid_o=1 for that cycle.
  - data_rdata_o holds its last value when no read is accepted.
- Out-of-range request (READY, data_re_i or data_we_i!=0):
  - No memory change.
  - Next cycle: data_err_o=1.
  - If it was a read, also data_rvalid_o=1 and data_rdata_o=0.
- Simultaneous read and write to the same word: read-first, so data_rdata_o returns the pre-write contents (see optional feature).
- Back-to-back reads are accepted every cycle with no bubbles. Throughput is 1 request per cycle.

Optional Feature:
- DATA_MEM_BYPASS_EN defined: a same-word simultaneous read+write returns write-first data. Each enabled lane comes from data_wdata_i; other lanes come from the old contents.
- Undefined: read-first as above.
- The macro affects only the same-word collision case.

Decomposition:
- Package data_mem_pkg:
  - dmem_state_e enum {INIT, READY}.
  - DMEM_WORD_BYTES=4.
  - Function byte_merge(old, new, we) returning the lane-merged word; used by both the write path and the bypass.
- Sub-module data_mem_init: the INIT/READY FSM plus sweep counter. Outputs ready, sweep_we, sweep_idx.
- The RAM array, address decode and read register stay in data_mem.

Test Plan:
- Sweep: DEPTH_WORDS=16, deassert rst → data_ready_o rises on cycle 16. A read at 0x8 issued at cycle 5 gives no rvalid. A read at 0x8 after ready gives 32'h0.
- Byte enables: write 0xAABBCCDD with we=4'hF at 0x4, then 0x11223344 with we=4'b0101 → read 0x4 returns 0xAA22CC44, with rvalid exactly 1 cycle after re.
- Range: BASE_ADDR=32'h1000, DEPTH_WORDS=16 → read 0x1040 gives err=1, rvalid=1, rdata=0. Write 0x0FFC gives err=1 and no change. Read 0x103C gives err=0. Read 32'hFFFF_FFFC gives err=1.
- Collision: mem[0x10]=0x0, same cycle write 0xDEADBEEF (we=4'hF) and read 0x10 → rdata=0x0 without the macro, 0xDEADBEEF with DATA_MEM_BYPASS_EN. A following read returns 0xDEADBEEF in both builds.
- Mid-sweep reset: DEPTH_WORDS=16, assert rst at sweep cycle 7 → ready stays low, the sweep restarts, and ready rises 16 cycles after rst deasserts. Data written before the reset reads back 0.
- Streaming: 8 back-to-back reads of 0x0..0x1C after writing pattern idx*0x01010101 → 8 consecutive rvalid cycles with correct data in order.
